// File: rtl/led_panel.sv
// Memory-mapped 8-bit LED port: a 4-byte register window on the CPU bus
// offering direct write, bit-set, bit-clear and bit-toggle, with combinational readback.
module led_panel #(
    parameter logic [15:0] BASE_ADDR = 16'hF200,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        read_hit,
    output logic [7:0]  leds
);

    // The initializer covers the interval before the first reset edge.
    logic [7:0] led_r = RESET_VAL;
    logic [7:0] led_next_s;
    logic       hit_s;

    assign hit_s = (address[15:2] == BASE_ADDR[15:2]);

    // Value the register takes on a write hit, selected by the window offset.
    always_comb begin
        led_next_s = led_r;
        case (address[1:0])
            2'd0:    led_next_s = data_in;
            2'd1:    led_next_s = led_r | data_in;
            2'd2:    led_next_s = led_r & ~data_in;
            2'd3:    led_next_s = led_r ^ data_in;
            default: led_next_s = led_r;
        endcase
    end

    // LED pattern register; reset wins over a same-edge write.
    always_ff @(posedge clock) begin
        if (reset) begin
            led_r <= RESET_VAL;
        end else if (write_en && hit_s) begin
            led_r <= led_next_s;
        end else begin
            led_r <= led_r;
        end
    end

    // Readback depends only on the address; write_en plays no part.
    always_comb begin
        data_out = 8'h00;
        read_hit = 1'b0;
        if (hit_s) begin
            data_out = led_r;
            read_hit = 1'b1;
        end else begin
            data_out = 8'h00;
            read_hit = 1'b0;
        end
    end

    assign leds = led_r;

endmodule

// File: tb/tb_led_panel.sv
// Self-checking bench for led_panel: directed scenarios followed by random bus
// traffic, all compared against a behavioural model of the LED register.
module tb_led_panel;

    localparam logic [15:0] BASE = 16'hF200;
    localparam logic [7:0]  RVAL = 8'h00;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] address = 16'h0000;
    logic        write_en = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        read_hit;
    logic [7:0]  leds;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  ref_led = RVAL;

    led_panel #(.BASE_ADDR(BASE), .RESET_VAL(RVAL)) dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .write_en (write_en),
        .data_in  (data_in),
        .data_out (data_out),
        .read_hit (read_hit),
        .leds     (leds)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_window(input logic [15:0] a);
        int off;
        off = int'(a) - int'(BASE);
        return (off >= 0) && (off <= 3);
    endfunction

    // Behavioural next-state: reset, then the four window operations by offset.
    function automatic logic [7:0] model_next(input logic [7:0] cur, input logic [15:0] a,
                                              input logic we, input logic [7:0] d, input logic rst);
        int off;
        if (rst) return RVAL;
        if (!we || !in_window(a)) return cur;
        off = int'(a) - int'(BASE);
        if (off == 0) return d;
        if (off == 1) return cur | d;
        if (off == 2) return cur & ~d;
        return cur ^ d;
    endfunction

    // One bus cycle: check readback before the edge, then leds after it.
    task automatic apply(input string tag, input logic [15:0] a, input logic we,
                         input logic [7:0] d, input logic rst);
        logic [7:0] exp;
        address  = a;
        write_en = we;
        data_in  = d;
        reset    = rst;
        #1;
        check({tag, ".data_out"}, data_out, in_window(a) ? ref_led : 8'h00);
        check({tag, ".read_hit"}, {7'd0, read_hit}, {7'd0, in_window(a)});
        exp = model_next(ref_led, a, we, d, rst);
        @(posedge clock);
        #1;
        ref_led  = exp;
        write_en = 1'b0;
        reset    = 1'b0;
        check({tag, ".leds"}, leds, ref_led);
    endtask

    initial begin
        logic [15:0] a;
        #1;
        check("init.leds", leds, RVAL);

        // 1: reset, direct write, readback at another offset
        apply("rst", BASE, 1'b0, 8'h00, 1'b1);
        check("rst.leds_zero", leds, 8'h00);
        apply("t1.data", BASE, 1'b1, 8'hA5, 1'b0);
        check("t1.leds_a5", leds, 8'hA5);
        apply("t1.read", BASE + 16'd2, 1'b0, 8'h00, 1'b0);
        check("t1.read_a5", data_out, 8'hA5);

        // 2: set / clear / toggle
        apply("t2.set", BASE + 16'd1, 1'b1, 8'h0A, 1'b0);
        check("t2.leds_af", leds, 8'hAF);
        apply("t2.clr", BASE + 16'd2, 1'b1, 8'hF0, 1'b0);
        check("t2.leds_0f", leds, 8'h0F);
        apply("t2.tog", BASE + 16'd3, 1'b1, 8'hFF, 1'b0);
        check("t2.leds_f0", leds, 8'hF0);
        apply("t2.set0", BASE + 16'd1, 1'b1, 8'h00, 1'b0);
        apply("t2.clr0", BASE + 16'd2, 1'b1, 8'h00, 1'b0);
        apply("t2.tog0", BASE + 16'd3, 1'b1, 8'h00, 1'b0);
        check("t2.zero_ops", leds, 8'hF0);

        // 3: misses, including both window neighbours
        apply("t3.ff00", 16'hFF00, 1'b1, 8'h55, 1'b0);
        apply("t3.base4", BASE + 16'd4, 1'b1, 8'h55, 1'b0);
        apply("t3.base_m1", BASE - 16'd1, 1'b1, 8'h55, 1'b0);
        check("t3.unchanged", leds, 8'hF0);

        // 4: reset beats a same-edge write
        apply("t4.rst_wr", BASE, 1'b1, 8'hFF, 1'b1);
        check("t4.leds_00", leds, 8'h00);

        // 5: toggle held for three edges
        apply("t5.tog1", BASE + 16'd3, 1'b1, 8'h81, 1'b0);
        check("t5.leds_81", leds, 8'h81);
        apply("t5.tog2", BASE + 16'd3, 1'b1, 8'h81, 1'b0);
        check("t5.leds_00", leds, 8'h00);
        apply("t5.tog3", BASE + 16'd3, 1'b1, 8'h81, 1'b0);
        check("t5.leds_81b", leds, 8'h81);

        // 6: CPU blink loop, one write every 8 cycles
        for (int k = 0; k < 6; k++) begin
            apply("t6.write", BASE, 1'b1, (k % 2 == 0) ? 8'h01 : 8'h80, 1'b0);
            check("t6.follow", leds, (k % 2 == 0) ? 8'h01 : 8'h80);
            for (int j = 0; j < 7; j++) begin
                apply("t6.hold", 16'h0100, 1'b0, 8'h00, 1'b0);
            end
        end

        // Random traffic concentrated on and around the window
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    a = BASE + 16'($urandom_range(0, 3));
                2:       a = BASE - 16'd1;
                3:       a = BASE + 16'd4;
                default: a = 16'($urandom);
            endcase
            apply("rnd", a, 1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 29) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
